boreal_adc_frame_capture: RTL and testbench

SPI frame-capture front end for the 8-channel biopotential ADC. On each data-ready event it clocks in one 216-bit frame (24-bit status plus 8×24-bit samples) and checks the status sync nibble. It then publishes the samples to boreal_apex_core_v3 as a stable `raw8` bus plus eight `adc_valid` strobes indexed by `ch`. The block sits directly upstream of the inference core and owns all ADC timing.

---
 rtl/boreal_adc_frame_capture_pkg.sv | 20 ++
 rtl/boreal_adc_frame_capture_sync2.sv | 24 ++
 rtl/boreal_adc_frame_capture.sv | 211 +++++++++++++++++++++
 tb/tb_boreal_adc_frame_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_adc_frame_capture_pkg.sv
// Shared constants and FSM state type for the biopotential ADC frame-capture front end.
package boreal_adc_pkg;

    localparam int N_CH        = 8;
    localparam int SAMPLE_W    = 24;
    localparam int STATUS_W    = 24;
    localparam int FRAME_BITS  = 216;
    localparam logic [3:0] SYNC_NIBBLE = 4'hC;
    localparam int PUB_CYCLES  = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        CHECK    = 3'd4,
        PUBLISH  = 3'd5
    } adc_state_t;

endpackage

// File: rtl/boreal_adc_frame_capture_sync2.sv
// Generic two-flop synchronizer; resets to 1 so an idle-high strobe never looks like a fall.
module boreal_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/boreal_adc_frame_capture.sv
// SPI frame capture for the 8-channel ADC: shifts in status + samples, checks sync, publishes per channel.
//
// state    | meaning
// IDLE     | waiting for a data-ready fall with en set
// CS_SETUP | chip select low, CLK_DIV cycles before first SCLK edge
// SHIFT    | 216 SCLK periods, MSB first, sample on SCLK fall
// CS_HOLD  | SCLK parked low, CLK_DIV cycles before releasing chip select
// CHECK    | sync nibble test, load raw8/status on a good frame
// PUBLISH  | 16 cycles of per-channel strobes on even slots
module boreal_adc_frame_capture
    import boreal_adc_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int N_CH     = 8,
    parameter int SAMPLE_W = 24,
    parameter int STATUS_W = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       drdy_n,
    input  logic                       adc_dout,
    output logic                       adc_cs_n,
    output logic                       adc_sclk,
    output logic [N_CH*SAMPLE_W-1:0]   raw8,
    output logic                       adc_valid,
    output logic [2:0]                 ch,
    output logic [STATUS_W-1:0]        status,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overrun,
    output logic [15:0]                frame_cnt
);

    localparam int         FRAME_W  = STATUS_W + N_CH * SAMPLE_W;
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] BIT_LOAD = 8'(FRAME_W - 1);
    localparam logic [3:0] PUB_LAST = 4'(PUB_CYCLES - 1);

    adc_state_t                  state_q, state_d;
    logic [7:0]                  div_q, div_d;
    logic [7:0]                  bit_q, bit_d;
    logic [3:0]                  pub_k_q, pub_k_d;
    logic [FRAME_W-1:0]          sr_q, sr_d;
    logic                        cs_n_q, cs_n_d;
    logic                        sclk_q, sclk_d;
    logic [N_CH*SAMPLE_W-1:0]    raw8_q, raw8_d;
    logic [STATUS_W-1:0]         status_q, status_d;
    logic                        valid_q, valid_d;
    logic [2:0]                  ch_q, ch_d;
    logic                        busy_q, busy_d;
    logic                        frame_err_q, frame_err_d;
    logic                        overrun_q, overrun_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;
    logic                        drdy_prev_q, drdy_prev_d;
    logic                        drdy_sync;
    logic                        drdy_fall;

    boreal_sync2 u_drdy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (drdy_n),
        .q     (drdy_sync)
    );

    assign drdy_prev_d = drdy_sync;
    assign drdy_fall   = drdy_prev_q & ~drdy_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            pub_k_q     <= '0;
            sr_q        <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            raw8_q      <= '0;
            status_q    <= '0;
            valid_q     <= 1'b0;
            ch_q        <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            drdy_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            pub_k_q     <= pub_k_d;
            sr_q        <= sr_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            raw8_q      <= raw8_d;
            status_q    <= status_d;
            valid_q     <= valid_d;
            ch_q        <= ch_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
            drdy_prev_q <= drdy_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        pub_k_d     = pub_k_q;
        sr_d        = sr_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        raw8_d      = raw8_q;
        status_d    = status_q;
        valid_d     = 1'b0;
        ch_d        = ch_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        // A fall outside IDLE is dropped, never queued.
        overrun_d   = drdy_fall && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (drdy_fall && en) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = DIV_LOAD;
                end
            end
            CS_SETUP: begin
                if (div_q == 8'd0) begin
                    state_d = SHIFT;
                    div_d   = DIV_LOAD;
                    bit_d   = BIT_LOAD;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            SHIFT: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    div_d = DIV_LOAD;
                    if (sclk_q) begin
                        // Capture on the same cycle SCLK is driven low.
                        sclk_d = 1'b0;
                        sr_d   = {sr_q[FRAME_W-2:0], adc_dout};
                    end else if (bit_q == 8'd0) begin
                        state_d = CS_HOLD;
                    end else begin
                        bit_d  = bit_q - 8'd1;
                        sclk_d = 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                if (div_q == 8'd0) begin
                    state_d = CHECK;
                    cs_n_d  = 1'b1;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            CHECK: begin
                if (sr_q[FRAME_W-1 -: 4] == SYNC_NIBBLE) begin
                    status_d = sr_q[FRAME_W-1 -: STATUS_W];
                    for (int i = 0; i < N_CH; i++) begin
                        raw8_d[i*SAMPLE_W +: SAMPLE_W] =
                            sr_q[FRAME_W-STATUS_W-1-i*SAMPLE_W -: SAMPLE_W];
                    end
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    pub_k_d     = 4'd0;
                    state_d     = PUBLISH;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            PUBLISH: begin
                // Odd slots hold ch so the consumer's read-modify-write settles.
                valid_d = ~pub_k_q[0];
                ch_d    = pub_k_q[3:1];
                if (pub_k_q == PUB_LAST) begin
                    state_d = IDLE;
                end else begin
                    pub_k_d = pub_k_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign adc_cs_n  = cs_n_q;
    assign adc_sclk  = sclk_q;
    assign raw8      = raw8_q;
    assign adc_valid = valid_q;
    assign ch        = ch_q;
    assign status    = status_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_boreal_adc_frame_capture.sv
// Directed bench for boreal_adc_frame_capture with a bit-serial ADC model on SCLK/CS.
module tb_boreal_adc_frame_capture;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         drdy_n;
    logic         adc_dout;
    logic         adc_cs_n;
    logic         adc_sclk;
    logic [191:0] raw8;
    logic         adc_valid;
    logic [2:0]   ch;
    logic [23:0]  status;
    logic         busy;
    logic         frame_err;
    logic         overrun;
    logic [15:0]  frame_cnt;

    boreal_adc_frame_capture #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .drdy_n    (drdy_n),
        .adc_dout  (adc_dout),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .raw8      (raw8),
        .adc_valid (adc_valid),
        .ch        (ch),
        .status    (status),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // ADC model: MSB presented at CS fall, next bit after every SCLK fall.
    logic [215:0] frame_bits = '0;
    int           idx = -1;
    always @(negedge adc_cs_n) idx = 215;
    always @(negedge adc_sclk) if (!adc_cs_n) idx = idx - 1;
    assign adc_dout = (idx >= 0 && idx <= 215) ? frame_bits[idx[7:0]] : 1'b0;

    int n_check = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int r_valid, r_err, r_ovr, r_first;
    logic r_ch_ok, r_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [215:0] mk_frame(input logic [23:0] st, input logic [191:0] chans);
        logic [215:0] f;
        f[215:192] = st;
        for (int i = 0; i < 8; i++) f[191-24*i -: 24] = chans[i*24 +: 24];
        return f;
    endfunction

    // Drops drdy_n, then watches one frame until busy falls; ovr_at > 0 adds a second fall.
    task automatic run_frame(input logic [215:0] f, input int ovr_at);
        logic       prev_v;
        logic [2:0] prev_ch;
        logic       seen_busy;
        int         last_v;
        frame_bits = f;
        r_valid = 0; r_err = 0; r_ovr = 0; r_first = -1; r_ch_ok = 1'b1; r_done = 1'b0;
        prev_v = 1'b0; prev_ch = 3'd0; seen_busy = 1'b0; last_v = 0;
        @(negedge clk);
        drdy_n = 1'b0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 20) drdy_n = 1'b1;
            if (ovr_at > 0 && cyc == ovr_at) drdy_n = 1'b0;
            if (ovr_at > 0 && cyc == ovr_at + 20) drdy_n = 1'b1;
            if (prev_v && ch !== prev_ch) r_ch_ok = 1'b0;
            if (adc_valid) begin
                if (r_first < 0) r_first = cyc;
                else if (cyc - last_v != 2) r_ch_ok = 1'b0;
                if (ch !== 3'(r_valid)) r_ch_ok = 1'b0;
                last_v = cyc;
                r_valid++;
            end
            prev_v  = adc_valid;
            prev_ch = ch;
            if (frame_err) r_err++;
            if (overrun) r_ovr++;
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) begin
                r_done = 1'b1;
                break;
            end
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    logic [191:0] chans1, chans2, chans3;
    logic [215:0] f1, f2, f3;
    logic         b_seen, c_seen, o_seen;

    initial begin
        for (int i = 0; i < 8; i++) begin
            chans1[i*24 +: 24] = 24'(i + 1);
            chans3[i*24 +: 24] = 24'h800000 | 24'(i * 24'h010203);
        end
        chans2 = chans1;
        chans2[3*24 +: 24] = 24'hFFFFFF;
        f1 = mk_frame(24'hC00000, chans1);
        f2 = mk_frame(24'h800000, chans2);
        f3 = mk_frame(24'hC5A5A5, chans3);

        rst_n = 1'b0; en = 1'b0; drdy_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_cs_n", 32'(adc_cs_n), 1);
        chk("rst_sclk", 32'(adc_sclk), 0);
        chk_bus("rst_raw8", raw8, '0);
        chk("rst_status", 32'(status), 0);
        chk("rst_ch", 32'(ch), 0);
        chk("rst_valid", 32'(adc_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_ovr", 32'({frame_err, overrun}), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1; en = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame: samples 1..8, first strobe at 3 + 4*434 + 2 cycles.
        run_frame(f1, 0);
        chk("f1_done", 32'(r_done), 1);
        chk("f1_first_strobe", r_first, 1741);
        chk("f1_strobes", r_valid, 8);
        chk("f1_ch_seq", 32'(r_ch_ok), 1);
        chk("f1_err_ovr", r_err + r_ovr, 0);
        chk_bus("f1_raw8", raw8, chans1);
        chk("f1_raw8_ch7", 32'(raw8[7*24 +: 24]), 8);
        chk("f1_status", 32'(status), 32'hC00000);
        chk("f1_frame_cnt", 32'(frame_cnt), 1);
        chk("f1_ch_end", 32'(ch), 7);
        chk("f1_cs_idle", 32'(adc_cs_n), 1);

        // Bad sync nibble: one error pulse, nothing published or reloaded.
        run_frame(f2, 0);
        chk("f2_done", 32'(r_done), 1);
        chk("f2_err", r_err, 1);
        chk("f2_strobes", r_valid, 0);
        chk_bus("f2_raw8_kept", raw8, chans1);
        chk("f2_status_kept", 32'(status), 32'hC00000);
        chk("f2_frame_cnt", 32'(frame_cnt), 1);

        // Second data-ready 500 cycles into SHIFT (SHIFT starts at cycle 7).
        run_frame(f3, 507);
        chk("f3_done", 32'(r_done), 1);
        chk("f3_overrun", r_ovr, 1);
        chk("f3_strobes", r_valid, 8);
        chk("f3_ch_seq", 32'(r_ch_ok), 1);
        chk_bus("f3_raw8", raw8, chans3);
        chk("f3_status", 32'(status), 32'hC5A5A5);
        chk("f3_frame_cnt", 32'(frame_cnt), 2);

        // Disabled: drdy_n toggles are ignored entirely.
        en = 1'b0; b_seen = 1'b0; c_seen = 1'b0; o_seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drdy_n = ((k % 60) < 30) ? 1'b0 : 1'b1;
            if (busy) b_seen = 1'b1;
            if (!adc_cs_n) c_seen = 1'b1;
            if (overrun) o_seen = 1'b1;
        end
        drdy_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("dis_busy", 32'(b_seen), 0);
        chk("dis_cs", 32'(c_seen), 0);
        chk("dis_overrun", 32'(o_seen), 0);
        en = 1'b1;
        run_frame(f1, 0);
        chk("en_done", 32'(r_done), 1);
        chk("en_strobes", r_valid, 8);
        chk_bus("en_raw8", raw8, chans1);
        chk("en_frame_cnt", 32'(frame_cnt), 3);

        // Reset during bit 100 of SHIFT.
        frame_bits = f3;
        @(negedge clk);
        drdy_n = 1'b0;
        r_done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!adc_cs_n) begin
                r_done = 1'b1;
                break;
            end
        end
        chk("mid_cs_low", 32'(r_done), 1);
        drdy_n = 1'b1;
        repeat (4 + 100 * 2 * 4) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_cs_n", 32'(adc_cs_n), 1);
        chk("mid_sclk", 32'(adc_sclk), 0);
        chk_bus("mid_raw8", raw8, '0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_frame_cnt", 32'(frame_cnt), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(f1, 0);
        chk("post_rst_done", 32'(r_done), 1);
        chk("post_rst_strobes", r_valid, 8);
        chk_bus("post_rst_raw8", raw8, chans1);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 1);

        // Fast-forward the good-frame counter to its top value, then wrap it.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        run_frame(f3, 0);
        chk("wrap_done", 32'(r_done), 1);
        chk("wrap_strobes", r_valid, 8);
        chk("wrap_frame_cnt", 32'(frame_cnt), 0);
        chk_bus("wrap_raw8", raw8, chans3);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
